// File: rtl/tsxb_fci_pkg.sv
// -----------------------------------------------------------------------------
// tsxb_fci_pkg
// Shared definitions for the FPGA side of the CPLD<->FPGA FCI link.
//   - FCI_S mux select codes (ZAL/ZAH/ZD/ZC)
//   - host FSM state encoding
//   - Z80 cycle-type record {mreq, iorq, rd, wr}
//   - counter width and the FCI_S select helper
// -----------------------------------------------------------------------------
package tsxb_fci_pkg;

   localparam logic [1:0] FCI_ZAL = 2'd0;
   localparam logic [1:0] FCI_ZAH = 2'd1;
   localparam logic [1:0] FCI_ZD  = 2'd2;
   localparam logic [1:0] FCI_ZC  = 2'd3;

   // Wide enough for both the settle delay and the read timeout.
   localparam int CNT_W = 8;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_AL    = 4'd1,
      ST_AH    = 4'd2,
      ST_DAT   = 4'd3,
      ST_STB   = 4'd4,
      ST_RWAIT = 4'd5,
      ST_TURN  = 4'd6,
      ST_DRIVE = 4'd7,
      ST_REL   = 4'd8,
      ST_END   = 4'd9
   } fci_state_t;

   typedef struct packed {
      logic mreq;
      logic iorq;
      logic rd;
      logic wr;
   } cyc_type_t;

   // FCI_S only moves when a new byte has to be fetched; in every other
   // state the CPLD mux keeps whatever field it was last showing.
   function automatic logic [1:0] fci_sel(input fci_state_t st, input logic [1:0] cur);
      logic [1:0] sel;
      case (st)
         ST_AL:   sel = FCI_ZAL;
         ST_AH:   sel = FCI_ZAH;
         ST_DAT:  sel = FCI_ZD;
         default: sel = cur;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/tsxb_sync2.sv
// -----------------------------------------------------------------------------
// tsxb_sync2
// Parameterised-width two-flop synchroniser with asynchronous active-low reset.
//   clk    in  1        destination clock
//   rst_n  in  1        asynchronous active-low reset (loads RST_VAL)
//   d      in  W        asynchronous inputs
//   q      out W        synchronised outputs
// -----------------------------------------------------------------------------
module tsxb_sync2 #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_r;
   logic [W-1:0] sync_r;

   // Two-stage capture chain; the first stage may go metastable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= RST_VAL;
         sync_r <= RST_VAL;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/tsxb_fci_host.sv
// -----------------------------------------------------------------------------
// tsxb_fci_host
// FPGA-side end of the CPLD<->FPGA FCI link. Detects Z80 memory/IO cycles on
// the buffered ZX-BUS strobes, walks the CPLD mux through address low, address
// high and (for writes) data, then issues one bus_stb on the internal bus. For
// reads it turns the FCI bus around and drives the responder data back until
// the strobe ends.
//
// Optional build macro: TSXB_FCI_TIMEOUT_EN -- a read with no bus_rvalid
// within RD_TIMEOUT cycles returns 8'hFF. Without it the read waits until
// bus_rvalid or the end of the strobe.
//
// Ports:
//   CLK50, RST_N                      clock, asynchronous active-low reset
//   FRD_N, FWR_N, FMRQ_N, FIORQ_N     ZX-BUS strobes from the CPLD (async)
//   FCI_I / FCI_O / FCI_OE            FCI pad in / out / output enable
//   FCI_S                             CPLD mux select (0 ZAL,1 ZAH,2 ZD,3 ZC)
//   FDIR                              1 = CPLD->FPGA, 0 = FPGA->CPLD
//   bus_addr, bus_wdata               captured address / write data
//   bus_mreq, bus_iorq, bus_rd, bus_wr cycle type, stable from bus_stb on
//   bus_stb                           one-cycle request pulse
//   bus_rdata, bus_rvalid             responder read data / valid pulse
//   busy                              FSM outside IDLE
// -----------------------------------------------------------------------------
module tsxb_fci_host
   import tsxb_fci_pkg::*;
#(
   parameter int SETTLE     = 2,
   parameter int RD_TIMEOUT = 15
) (
   input  logic        CLK50,
   input  logic        RST_N,
   input  logic        FRD_N,
   input  logic        FWR_N,
   input  logic        FMRQ_N,
   input  logic        FIORQ_N,
   input  logic [7:0]  FCI_I,
   output logic [7:0]  FCI_O,
   output logic        FCI_OE,
   output logic [1:0]  FCI_S,
   output logic        FDIR,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_mreq,
   output logic        bus_iorq,
   output logic        bus_rd,
   output logic        bus_wr,
   output logic        bus_stb,
   input  logic [7:0]  bus_rdata,
   input  logic        bus_rvalid,
   output logic        busy
);

   localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(RD_TIMEOUT - 1);

   // Synchronised strobes, ordered {rd, wr, mrq, iorq}, still active-low.
   logic [3:0] strb_n_s;
   cyc_type_t  cyc_s;
   logic       act_s;
   logic       act_r;
   logic       act_d_r;
   cyc_type_t  cyc_r;
   logic       start_s;

   fci_state_t       state_r;
   fci_state_t       state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic             cnt_done_s;

   logic [15:0] bus_addr_r,  addr_nxt_s;
   logic [7:0]  bus_wdata_r, wdata_nxt_s;
   cyc_type_t   cyc_out_r,   cyc_nxt_s;
   logic [7:0]  fci_o_r,     fci_o_nxt_s;
   logic        fci_oe_r,    oe_nxt_s;
   logic        fdir_r,      fdir_nxt_s;
   logic [1:0]  fci_s_r,     sel_nxt_s;
   logic        bus_stb_r,   stb_nxt_s;
   logic        busy_r,      busy_nxt_s;

   // Idle strobes are high, so the synchroniser resets to all ones.
   tsxb_sync2 #(
      .W       (4),
      .RST_VAL (4'hF)
   ) u_sync (
      .clk   (CLK50),
      .rst_n (RST_N),
      .d     ({FRD_N, FWR_N, FMRQ_N, FIORQ_N}),
      .q     (strb_n_s)
   );

   // Decode the synchronised strobes into cycle type and activity.
   always_comb begin
      cyc_s.rd   = ~strb_n_s[3];
      cyc_s.wr   = ~strb_n_s[2];
      cyc_s.mreq = ~strb_n_s[1];
      cyc_s.iorq = ~strb_n_s[0];
      // Refresh (MRQ alone) has neither RD nor WR and never counts as active.
      act_s      = (cyc_s.rd | cyc_s.wr) & (cyc_s.mreq | cyc_s.iorq);
   end

   // Register activity and type together so the type latched at the act edge
   // belongs to the same sample that raised act.
   always_ff @(posedge CLK50 or negedge RST_N) begin
      if (!RST_N) begin
         act_r   <= 1'b0;
         act_d_r <= 1'b0;
         cyc_r   <= '0;
      end else begin
         act_r   <= act_s;
         act_d_r <= act_r;
         cyc_r   <= cyc_s;
      end
   end

   assign start_s    = act_r & ~act_d_r;
   assign cnt_done_s = (cnt_r == {CNT_W{1'b0}});

   // FSM state register.
   always_ff @(posedge CLK50 or negedge RST_N) begin
      if (!RST_N) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) state_nxt_s = ST_AL;
            else         state_nxt_s = ST_IDLE;
         end
         ST_AL: begin
            if (!act_r)          state_nxt_s = ST_IDLE;
            else if (cnt_done_s) state_nxt_s = ST_AH;
            else                 state_nxt_s = ST_AL;
         end
         ST_AH: begin
            if (!act_r)          state_nxt_s = ST_IDLE;
            else if (cnt_done_s) state_nxt_s = cyc_out_r.wr ? ST_DAT : ST_STB;
            else                 state_nxt_s = ST_AH;
         end
         ST_DAT: begin
            if (!act_r)          state_nxt_s = ST_IDLE;
            else if (cnt_done_s) state_nxt_s = ST_STB;
            else                 state_nxt_s = ST_DAT;
         end
         ST_STB: begin
            // A responder may answer in the very cycle of the strobe.
            if (cyc_out_r.wr)    state_nxt_s = ST_END;
            else if (bus_rvalid) state_nxt_s = ST_TURN;
            else                 state_nxt_s = ST_RWAIT;
         end
         ST_RWAIT: begin
            if (!act_r)          state_nxt_s = ST_IDLE;
            else if (bus_rvalid) state_nxt_s = ST_TURN;
`ifdef TSXB_FCI_TIMEOUT_EN
            else if (cnt_done_s) state_nxt_s = ST_TURN;
`endif
            else                 state_nxt_s = ST_RWAIT;
         end
         ST_TURN: begin
            // Strobe already gone: skip driving, just restore direction.
            if (!act_r) state_nxt_s = ST_REL;
            else        state_nxt_s = ST_DRIVE;
         end
         ST_DRIVE: begin
            if (!act_r) state_nxt_s = ST_REL;
            else        state_nxt_s = ST_DRIVE;
         end
         ST_REL: begin
            state_nxt_s = ST_IDLE;
         end
         ST_END: begin
            if (!act_r) state_nxt_s = ST_IDLE;
            else        state_nxt_s = ST_END;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM output logic: next values of all registered outputs.
   always_comb begin
      addr_nxt_s  = bus_addr_r;
      wdata_nxt_s = bus_wdata_r;
      cyc_nxt_s   = cyc_out_r;
      fci_o_nxt_s = fci_o_r;
      oe_nxt_s    = fci_oe_r;
      fdir_nxt_s  = fdir_r;
      sel_nxt_s   = fci_sel(state_nxt_s, fci_s_r);
      stb_nxt_s   = (state_nxt_s == ST_STB);
      busy_nxt_s  = (state_nxt_s != ST_IDLE);
      case (state_r)
         ST_IDLE: begin
            if (state_nxt_s == ST_AL) begin
               cyc_nxt_s   = cyc_r;
               wdata_nxt_s = 8'h00;
            end else begin
               cyc_nxt_s   = cyc_out_r;
            end
         end
         ST_AL: begin
            if (state_nxt_s == ST_AH) addr_nxt_s[7:0] = FCI_I;
            else                      addr_nxt_s      = bus_addr_r;
         end
         ST_AH: begin
            if (act_r && cnt_done_s) addr_nxt_s[15:8] = FCI_I;
            else                     addr_nxt_s       = bus_addr_r;
         end
         ST_DAT: begin
            if (state_nxt_s == ST_STB) wdata_nxt_s = FCI_I;
            else                       wdata_nxt_s = bus_wdata_r;
         end
         ST_STB, ST_RWAIT: begin
            // Only a timeout reaches TURN without bus_rvalid.
            if (state_nxt_s == ST_TURN) begin
               fdir_nxt_s  = 1'b0;
               fci_o_nxt_s = bus_rvalid ? bus_rdata : 8'hFF;
            end else begin
               fdir_nxt_s  = fdir_r;
            end
         end
         ST_TURN: begin
            // FDIR already fell last cycle, so enabling the pad now is safe.
            oe_nxt_s = (state_nxt_s == ST_DRIVE);
         end
         ST_DRIVE: begin
            oe_nxt_s = (state_nxt_s == ST_DRIVE);
         end
         ST_REL: begin
            // Pad released one cycle ago; hand the bus back to the CPLD.
            fdir_nxt_s = 1'b1;
         end
         default: begin
            fdir_nxt_s = fdir_r;
         end
      endcase
   end

   // Settle / timeout counter, reloaded whenever the FSM changes state.
   always_ff @(posedge CLK50 or negedge RST_N) begin
      if (!RST_N) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (state_nxt_s != state_r) begin
         cnt_r <= (state_nxt_s == ST_RWAIT) ? TIMEOUT_LD : SETTLE_LD;
      end else if (!cnt_done_s) begin
         cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Output registers; reset drops FCI_OE and raises FDIR immediately.
   always_ff @(posedge CLK50 or negedge RST_N) begin
      if (!RST_N) begin
         bus_addr_r  <= 16'h0000;
         bus_wdata_r <= 8'h00;
         cyc_out_r   <= '0;
         fci_o_r     <= 8'h00;
         fci_oe_r    <= 1'b0;
         fdir_r      <= 1'b1;
         fci_s_r     <= FCI_ZAL;
         bus_stb_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         bus_addr_r  <= addr_nxt_s;
         bus_wdata_r <= wdata_nxt_s;
         cyc_out_r   <= cyc_nxt_s;
         fci_o_r     <= fci_o_nxt_s;
         fci_oe_r    <= oe_nxt_s;
         fdir_r      <= fdir_nxt_s;
         fci_s_r     <= sel_nxt_s;
         bus_stb_r   <= stb_nxt_s;
         busy_r      <= busy_nxt_s;
      end
   end

   assign bus_addr  = bus_addr_r;
   assign bus_wdata = bus_wdata_r;
   assign bus_mreq  = cyc_out_r.mreq;
   assign bus_iorq  = cyc_out_r.iorq;
   assign bus_rd    = cyc_out_r.rd;
   assign bus_wr    = cyc_out_r.wr;
   assign bus_stb   = bus_stb_r;
   assign busy      = busy_r;
   assign FCI_O     = fci_o_r;
   assign FCI_OE    = fci_oe_r;
   assign FDIR      = fdir_r;
   assign FCI_S     = fci_s_r;

endmodule

// File: tb/tb_tsxb_fci_host.sv
// -----------------------------------------------------------------------------
// tb_tsxb_fci_host
// Directed bench for tsxb_fci_host with SETTLE=2, RD_TIMEOUT=15. A small
// combinational model of the CPLD mux feeds FCI_I from the field selected by
// FCI_S. Inputs change 1 time unit after a rising edge; outputs are read there.
// -----------------------------------------------------------------------------
module tb_tsxb_fci_host;

   logic        CLK50 = 1'b0;
   logic        RST_N = 1'b0;
   logic        FRD_N = 1'b1, FWR_N = 1'b1, FMRQ_N = 1'b1, FIORQ_N = 1'b1;
   logic [7:0]  FCI_I;
   logic [7:0]  FCI_O;
   logic        FCI_OE;
   logic [1:0]  FCI_S;
   logic        FDIR;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_mreq, bus_iorq, bus_rd, bus_wr, bus_stb, busy;
   logic [7:0]  bus_rdata  = 8'h00;
   logic        bus_rvalid = 1'b0;

   logic [7:0]  zal = 8'h00, zah = 8'h00, zd = 8'h00;

   int n_cmp = 0;
   int n_bad = 0;

   // Event monitors (only ever written here)
   int          stb_cnt = 0, fdir_low_cnt = 0, busy_cnt = 0, oe_cnt = 0, clash_cnt = 0;
   logic [11:0] s_hist = 12'h000;
   logic        prev_busy = 1'b0;
   logic [1:0]  prev_s = 2'd0;

   tsxb_fci_host #(.SETTLE(2), .RD_TIMEOUT(15)) dut (
      .CLK50(CLK50), .RST_N(RST_N),
      .FRD_N(FRD_N), .FWR_N(FWR_N), .FMRQ_N(FMRQ_N), .FIORQ_N(FIORQ_N),
      .FCI_I(FCI_I), .FCI_O(FCI_O), .FCI_OE(FCI_OE), .FCI_S(FCI_S), .FDIR(FDIR),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_mreq(bus_mreq), .bus_iorq(bus_iorq), .bus_rd(bus_rd), .bus_wr(bus_wr),
      .bus_stb(bus_stb), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .busy(busy)
   );

   always #5 CLK50 = ~CLK50;

   // CPLD mux model
   assign FCI_I = (FCI_S == 2'd0) ? zal : (FCI_S == 2'd1) ? zah : (FCI_S == 2'd2) ? zd : 8'h00;

   always @(posedge CLK50) begin
      if (bus_stb) stb_cnt <= stb_cnt + 1;
   end

   always @(negedge CLK50) begin
      if (!FDIR) fdir_low_cnt <= fdir_low_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
      if (FCI_OE) oe_cnt <= oe_cnt + 1;
      if (FCI_OE && FDIR) clash_cnt <= clash_cnt + 1;
      if (busy && (!prev_busy || FCI_S != prev_s)) s_hist <= {s_hist[9:0], FCI_S};
      prev_busy <= busy;
      prev_s    <= FCI_S;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit=200000");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK50);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Edges from strobe drive to bus_stb high; 0 when it never came.
   task automatic wait_stb(output int lat);
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (bus_stb) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #12;
      n_cmp++; if (FDIR !== 1'b1) begin n_bad++; $display("FAIL rst_fdir got=%b exp=1", FDIR); end
      n_cmp++; if ({FCI_OE, FCI_O, FCI_S} !== 11'h000) begin n_bad++; $display("FAIL rst_fci got=%h exp=000", {FCI_OE, FCI_O, FCI_S}); end
      n_cmp++; if ({bus_addr, bus_wdata, bus_mreq, bus_iorq, bus_rd, bus_wr, bus_stb, busy} !== 30'h0) begin
         n_bad++; $display("FAIL rst_bus got=%h exp=0", {bus_addr, bus_wdata, bus_mreq, bus_iorq, bus_rd, bus_wr, bus_stb, busy}); end
      tick();
      RST_N = 1'b1;
      ticks(3);
   endtask

   task automatic test_io_write();
      int lat, s0, f0;
      zal = 8'hAF; zah = 8'hE0; zd = 8'h5A;
      s0 = stb_cnt; f0 = fdir_low_cnt;
      FIORQ_N = 1'b0; FWR_N = 1'b0;
      wait_stb(lat);
      // 2 sync + act register + edge detect + 3 fields * SETTLE = 10
      n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL wr_latency got=%0d exp=10", lat); end
      n_cmp++; if (bus_addr !== 16'hE0AF) begin n_bad++; $display("FAIL wr_addr got=%h exp=e0af", bus_addr); end
      n_cmp++; if (bus_wdata !== 8'h5A) begin n_bad++; $display("FAIL wr_data got=%h exp=5a", bus_wdata); end
      n_cmp++; if ({bus_mreq, bus_iorq, bus_rd, bus_wr} !== 4'b0101) begin n_bad++; $display("FAIL wr_type got=%b exp=0101", {bus_mreq, bus_iorq, bus_rd, bus_wr}); end
      ticks(4);
      FIORQ_N = 1'b1; FWR_N = 1'b1;
      ticks(6);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_idle got=%b exp=0", busy); end
      n_cmp++; if (stb_cnt - s0 !== 1) begin n_bad++; $display("FAIL wr_stb_count got=%0d exp=1", stb_cnt - s0); end
      n_cmp++; if (fdir_low_cnt - f0 !== 0) begin n_bad++; $display("FAIL wr_fdir_low got=%0d exp=0", fdir_low_cnt - f0); end
      n_cmp++; if (s_hist[5:0] !== 6'b00_01_10) begin n_bad++; $display("FAIL wr_fci_s_seq got=%b exp=000110", s_hist[5:0]); end
   endtask

   task automatic test_mem_read();
      int lat, n;
      zal = 8'h00; zah = 8'h40;
      FMRQ_N = 1'b0; FRD_N = 1'b0;
      wait_stb(lat);
      n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL rd_latency got=%0d exp=8", lat); end
      n_cmp++; if ({bus_addr, bus_wdata} !== 24'h400000) begin n_bad++; $display("FAIL rd_addr got=%h exp=400000", {bus_addr, bus_wdata}); end
      n_cmp++; if ({bus_mreq, bus_iorq, bus_rd, bus_wr} !== 4'b1010) begin n_bad++; $display("FAIL rd_type got=%b exp=1010", {bus_mreq, bus_iorq, bus_rd, bus_wr}); end
      ticks(3);
      bus_rdata = 8'hC3; bus_rvalid = 1'b1;
      tick();
      bus_rvalid = 1'b0;
      n_cmp++; if ({FDIR, FCI_OE} !== 2'b00) begin n_bad++; $display("FAIL rd_turn got=%b exp=00", {FDIR, FCI_OE}); end
      tick();
      n_cmp++; if ({FDIR, FCI_OE, FCI_O} !== 10'h1C3) begin n_bad++; $display("FAIL rd_drive got=%h exp=1c3", {FDIR, FCI_OE, FCI_O}); end
      ticks(4);
      n_cmp++; if ({FCI_OE, FCI_O} !== 9'h1C3) begin n_bad++; $display("FAIL rd_hold got=%h exp=1c3", {FCI_OE, FCI_O}); end
      FRD_N = 1'b1; FMRQ_N = 1'b1;
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (!FCI_OE) begin n = i; break; end
      end
      n_cmp++; if (n == 0 || FDIR !== 1'b0) begin n_bad++; $display("FAIL rd_release got=oe%b/fdir%b exp=oe0/fdir0", FCI_OE, FDIR); end
      tick();
      n_cmp++; if ({FDIR, busy} !== 2'b10) begin n_bad++; $display("FAIL rd_fdir_back got=%b exp=10", {FDIR, busy}); end
      n_cmp++; if (s_hist[3:0] !== 4'b00_01) begin n_bad++; $display("FAIL rd_fci_s_seq got=%b exp=0001", s_hist[3:0]); end
   endtask

   task automatic test_refresh();
      int b0, s0;
      b0 = busy_cnt; s0 = stb_cnt;
      FMRQ_N = 1'b0;
      ticks(4);
      bus_rdata = 8'h77; bus_rvalid = 1'b1;
      tick();
      bus_rvalid = 1'b0;
      ticks(4);
      FMRQ_N = 1'b1;
      ticks(5);
      n_cmp++; if (busy_cnt - b0 !== 0) begin n_bad++; $display("FAIL refresh_busy got=%0d exp=0", busy_cnt - b0); end
      n_cmp++; if (stb_cnt - s0 !== 0) begin n_bad++; $display("FAIL refresh_stb got=%0d exp=0", stb_cnt - s0); end
      n_cmp++; if (FCI_O !== 8'hC3) begin n_bad++; $display("FAIL idle_rvalid_ignored got=%h exp=c3", FCI_O); end
   endtask

   task automatic test_abort_write();
      int s0, f0, lat;
      bit seen, idle;
      zal = 8'h34; zah = 8'h12; zd = 8'h99;
      s0 = stb_cnt; f0 = fdir_low_cnt;
      FMRQ_N = 1'b0; FWR_N = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (busy && FCI_S == 2'd1) begin seen = 1'b1; break; end
      end
      FWR_N = 1'b1;
      idle = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!busy) begin idle = 1'b1; break; end
      end
      n_cmp++; if ({seen, idle} !== 2'b11) begin n_bad++; $display("FAIL abort_return got=%b exp=11", {seen, idle}); end
      n_cmp++; if (stb_cnt - s0 !== 0) begin n_bad++; $display("FAIL abort_no_stb got=%0d exp=0", stb_cnt - s0); end
      n_cmp++; if (fdir_low_cnt - f0 !== 0) begin n_bad++; $display("FAIL abort_fdir got=%0d exp=0", fdir_low_cnt - f0); end
      FMRQ_N = 1'b1;
      ticks(3);
      zal = 8'h78; zah = 8'h56; zd = 8'hA5;
      FMRQ_N = 1'b0; FWR_N = 1'b0;
      wait_stb(lat);
      n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL abort_next_latency got=%0d exp=10", lat); end
      n_cmp++; if ({bus_addr, bus_wdata} !== 24'h5678A5) begin n_bad++; $display("FAIL abort_next_data got=%h exp=5678a5", {bus_addr, bus_wdata}); end
      n_cmp++; if ({bus_mreq, bus_iorq, bus_rd, bus_wr} !== 4'b1001) begin n_bad++; $display("FAIL abort_next_type got=%b exp=1001", {bus_mreq, bus_iorq, bus_rd, bus_wr}); end
      ticks(3);
      FMRQ_N = 1'b1; FWR_N = 1'b1;
      ticks(6);
      n_cmp++; if (stb_cnt - s0 !== 1) begin n_bad++; $display("FAIL abort_next_stb got=%0d exp=1", stb_cnt - s0); end
   endtask

   task automatic test_timeout_read();
      int lat, o0;
      zal = 8'h11; zah = 8'h22;
      FMRQ_N = 1'b0; FRD_N = 1'b0;
      wait_stb(lat);
      n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL to_latency got=%0d exp=8", lat); end
      o0 = oe_cnt;
`ifdef TSXB_FCI_TIMEOUT_EN
      begin
         int n;
         n = 0;
         for (int i = 1; i <= 40; i++) begin
            tick();
            if (!FDIR) begin n = i; break; end
         end
         // STB -> RWAIT (15 counted cycles) -> TURN on the 16th edge
         n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL to_expiry got=%0d exp=16", n); end
         n_cmp++; if ({FCI_OE, FCI_O} !== 9'h0FF) begin n_bad++; $display("FAIL to_data got=%h exp=0ff", {FCI_OE, FCI_O}); end
         tick();
         n_cmp++; if (FCI_OE !== 1'b1) begin n_bad++; $display("FAIL to_drive got=%b exp=1", FCI_OE); end
      end
`else
      ticks(40);
      n_cmp++; if ({FDIR, busy} !== 2'b11) begin n_bad++; $display("FAIL to_wait got=%b exp=11", {FDIR, busy}); end
`endif
      FRD_N = 1'b1; FMRQ_N = 1'b1;
      ticks(8);
      n_cmp++; if ({FDIR, FCI_OE, busy} !== 3'b100) begin n_bad++; $display("FAIL to_end got=%b exp=100", {FDIR, FCI_OE, busy}); end
`ifndef TSXB_FCI_TIMEOUT_EN
      n_cmp++; if (oe_cnt - o0 !== 0) begin n_bad++; $display("FAIL to_no_oe got=%0d exp=0", oe_cnt - o0); end
`endif
   endtask

   task automatic test_reset_in_drive();
      int lat;
      bit seen;
      zal = 8'hCD; zah = 8'hAB;
      FMRQ_N = 1'b0; FRD_N = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus_stb) begin
            bus_rdata = 8'h96; bus_rvalid = 1'b1;   // answer in the strobe cycle
            seen = 1'b1;
            break;
         end
      end
      tick();
      bus_rvalid = 1'b0;
      n_cmp++; if ({seen, FDIR, FCI_OE} !== 3'b100) begin n_bad++; $display("FAIL same_cycle_rvalid got=%b exp=100", {seen, FDIR, FCI_OE}); end
      tick();
      n_cmp++; if ({FCI_OE, FCI_O} !== 9'h196) begin n_bad++; $display("FAIL same_cycle_drive got=%h exp=196", {FCI_OE, FCI_O}); end
      ticks(2);
      #2;
      RST_N = 1'b0;
      FRD_N = 1'b1; FMRQ_N = 1'b1;
      #1;
      n_cmp++; if ({FCI_OE, FDIR, busy} !== 3'b010) begin n_bad++; $display("FAIL async_reset got=%b exp=010", {FCI_OE, FDIR, busy}); end
      ticks(2);
      RST_N = 1'b1;
      ticks(3);
      zal = 8'hFF; zah = 8'h00; zd = 8'h3C;
      FIORQ_N = 1'b0; FWR_N = 1'b0;
      wait_stb(lat);
      n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL post_reset_latency got=%0d exp=10", lat); end
      n_cmp++; if ({bus_addr, bus_wdata} !== 24'h00FF3C) begin n_bad++; $display("FAIL post_reset_data got=%h exp=00ff3c", {bus_addr, bus_wdata}); end
      n_cmp++; if ({bus_mreq, bus_iorq, bus_rd, bus_wr} !== 4'b0101) begin n_bad++; $display("FAIL post_reset_type got=%b exp=0101", {bus_mreq, bus_iorq, bus_rd, bus_wr}); end
      ticks(3);
      FIORQ_N = 1'b1; FWR_N = 1'b1;
      ticks(6);
      n_cmp++; if ({busy, FDIR} !== 2'b01) begin n_bad++; $display("FAIL post_reset_idle got=%b exp=01", {busy, FDIR}); end
      n_cmp++; if (clash_cnt !== 0) begin n_bad++; $display("FAIL oe_with_fdir_high got=%0d exp=0", clash_cnt); end
   endtask

   initial begin
      test_reset();
      test_io_write();
      test_mem_read();
      test_refresh();
      test_abort_write();
      test_timeout_read();
      test_reset_in_drive();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
